// File: rtl/code_lock_fsm_if.sv
// Button/status bundle between the debouncer side and the code lock.
// LOCK_REPROGRAM_EN adds the prog strobe used to enter a new code.
interface code_lock_fsm_if;
    logic [3:0] btn;
    logic       unlocked;
    logic       error;
    logic       locked_out;
    logic [2:0] digit_count;
`ifdef LOCK_REPROGRAM_EN
    logic       prog;

    modport master (
        output btn, prog,
        input  unlocked, error, locked_out, digit_count
    );
    modport slave (
        input  btn, prog,
        output unlocked, error, locked_out, digit_count
    );
`else
    modport master (
        output btn,
        input  unlocked, error, locked_out, digit_count
    );
    modport slave (
        input  btn,
        output unlocked, error, locked_out, digit_count
    );
`endif
endinterface

// File: rtl/code_lock_fsm.sv
// Combination lock: press-edge digit entry, auto-relock, lockout on failures.
// Optional LOCK_REPROGRAM_EN lets the code be rewritten while open.
module code_lock_fsm #(
    parameter int          CODE_LEN       = 4,
    parameter logic [15:0] CODE           = 16'h1B00,
    parameter int          UNLOCK_CYCLES  = 50000000,
    parameter int          MAX_FAILS      = 3,
    parameter int          LOCKOUT_CYCLES = 100000000
) (
    input logic            clk,
    input logic            reset,
    code_lock_fsm_if.slave bus
);
    localparam int CW = 2 * CODE_LEN;
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam logic [CW-1:0] CODE_INIT = CODE[CW-1:0];
    localparam logic [31:0]   OPEN_LAST = 32'(UNLOCK_CYCLES - 1);
    localparam logic [31:0]   LOCK_LAST = 32'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]    LAST_IDX  = 3'(CODE_LEN - 1);
    localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAILS);
    localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAILS - 1);

    typedef enum logic [1:0] {
        ENTRY,
        OPEN,
        LOCKOUT,
        SETCODE
    } state_t;

    state_t        state;
    logic [3:0]    btn_prev;
    logic [31:0]   timer;
    logic [FW-1:0] fail_cnt;
    logic          mismatch;
    logic [2:0]    digit_count;
    logic          unlocked_q;
    logic          error_q;
    logic          locked_out_q;
    logic [CW-1:0] code_q;

    logic [3:0] rise;
    logic       press;
    logic       multi;
    logic [1:0] digit;
    logic [1:0] exp_digit;
    logic       mism_next;

`ifdef LOCK_REPROGRAM_EN
    logic [CW-1:0] new_code;
    logic [CW-1:0] stage_code;
    logic [2:0]    set_idx;

    always_comb begin
        stage_code = new_code;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (set_idx == 3'(i)) stage_code[2*i +: 2] = digit;
        end
    end
`else
    assign code_q = CODE_INIT;
`endif

    assign rise  = bus.btn & ~btn_prev;
    assign press = |rise;
    assign multi = |(rise & (rise - 4'd1));

    always_comb begin
        digit = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rise[i]) digit = 2'(i);
        end
    end

    always_comb begin
        exp_digit = 2'd0;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (digit_count == 3'(i)) exp_digit = code_q[2*i +: 2];
        end
    end

    assign mism_next = mismatch | multi | (digit != exp_digit);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ENTRY;
            btn_prev     <= 4'b1111;
            timer        <= '0;
            fail_cnt     <= '0;
            mismatch     <= 1'b0;
            digit_count  <= '0;
            unlocked_q   <= 1'b0;
            error_q      <= 1'b0;
            locked_out_q <= 1'b0;
`ifdef LOCK_REPROGRAM_EN
            code_q       <= CODE_INIT;
            new_code     <= CODE_INIT;
            set_idx      <= '0;
`endif
        end else begin
            btn_prev <= bus.btn;
            error_q  <= 1'b0;
            unique case (state)
                ENTRY: begin
                    if (press) begin
                        if (digit_count == LAST_IDX) begin
                            digit_count <= '0;
                            mismatch    <= 1'b0;
                            timer       <= '0;
                            if (!mism_next) begin
                                state      <= OPEN;
                                unlocked_q <= 1'b1;
                                fail_cnt   <= '0;
                            end else begin
                                error_q <= 1'b1;
                                if (fail_cnt != FAIL_MAX)
                                    fail_cnt <= fail_cnt + 1'b1;
                                if (fail_cnt >= FAIL_LAST) begin
                                    state        <= LOCKOUT;
                                    locked_out_q <= 1'b1;
                                end
                            end
                        end else begin
                            digit_count <= digit_count + 3'd1;
                            mismatch    <= mism_next;
                        end
                    end
                end
                OPEN: begin
`ifdef LOCK_REPROGRAM_EN
                    if (press && bus.prog) begin
                        new_code <= stage_code;
                        if (CODE_LEN == 1) begin
                            code_q     <= stage_code;
                            state      <= ENTRY;
                            unlocked_q <= 1'b0;
                            timer      <= '0;
                        end else begin
                            state   <= SETCODE;
                            set_idx <= 3'd1;
                        end
                    end else
`endif
                    if (press || timer == OPEN_LAST) begin
                        state      <= ENTRY;
                        unlocked_q <= 1'b0;
                        timer      <= '0;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                LOCKOUT: begin
                    if (timer == LOCK_LAST) begin
                        state        <= ENTRY;
                        locked_out_q <= 1'b0;
                        fail_cnt     <= '0;
                        timer        <= '0;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                SETCODE: begin
`ifdef LOCK_REPROGRAM_EN
                    if (press) begin
                        new_code <= stage_code;
                        if (set_idx == LAST_IDX) begin
                            code_q     <= stage_code;
                            state      <= ENTRY;
                            unlocked_q <= 1'b0;
                            timer      <= '0;
                            set_idx    <= '0;
                        end else begin
                            set_idx <= set_idx + 3'd1;
                        end
                    end
`else
                    state      <= ENTRY;
                    unlocked_q <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign bus.unlocked    = unlocked_q;
    assign bus.error       = error_q;
    assign bus.locked_out  = locked_out_q;
    assign bus.digit_count = digit_count;
endmodule

// File: tb/tb_code_lock_fsm.sv
// Directed bench for code_lock_fsm: code 0,1,2,3, short timers.
// Reprogramming checks run when LOCK_REPROGRAM_EN is defined.
module tb_code_lock_fsm;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    code_lock_fsm_if bus ();

    code_lock_fsm #(
        .CODE_LEN      (4),
        .CODE          (16'h00E4),
        .UNLOCK_CYCLES (20),
        .MAX_FAILS     (3),
        .LOCKOUT_CYCLES(30)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic press(input int d);
        @(negedge clk);
        bus.btn = 4'(1 << d);
        @(negedge clk);
        bus.btn = 4'b0000;
    endtask

    task automatic enter(input int a, input int b, input int c, input int e);
        press(a);
        press(b);
        press(c);
        press(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        bus.btn = 4'b0000;
`ifdef LOCK_REPROGRAM_EN
        bus.prog = 1'b0;
`endif
        idle(3);
        check("rst_unlocked", 32'(bus.unlocked), 32'd0);
        check("rst_error", 32'(bus.error), 32'd0);
        check("rst_lockout", 32'(bus.locked_out), 32'd0);
        check("rst_count", 32'(bus.digit_count), 32'd0);
        reset = 1'b0;
        idle(2);

        // 1: correct code, auto relock after 20 cycles
        press(0);
        check("t1_cnt1", 32'(bus.digit_count), 32'd1);
        press(1);
        check("t1_cnt2", 32'(bus.digit_count), 32'd2);
        press(2);
        check("t1_cnt3", 32'(bus.digit_count), 32'd3);
        press(3);
        check("t1_cnt0", 32'(bus.digit_count), 32'd0);
        check("t1_open", 32'(bus.unlocked), 32'd1);
        idle(19);
        check("t1_open_k19", 32'(bus.unlocked), 32'd1);
        idle(1);
        check("t1_relock_k20", 32'(bus.unlocked), 32'd0);

        // 2: wrong code then right code, press in OPEN relocks
        enter(0, 1, 2, 2);
        check("t2_err", 32'(bus.error), 32'd1);
        check("t2_locked", 32'(bus.unlocked), 32'd0);
        check("t2_cnt", 32'(bus.digit_count), 32'd0);
        idle(1);
        check("t2_err_width", 32'(bus.error), 32'd0);
        enter(0, 1, 2, 3);
        check("t2_open", 32'(bus.unlocked), 32'd1);
        press(2);
        check("t2_press_relock", 32'(bus.unlocked), 32'd0);
        check("t2_press_nocnt", 32'(bus.digit_count), 32'd0);

        // 3: three failures -> lockout for 30 cycles
        enter(1, 1, 1, 1);
        check("t3_err1", 32'(bus.error), 32'd1);
        enter(1, 1, 1, 1);
        check("t3_err2_nolock", 32'(bus.locked_out), 32'd0);
        enter(1, 1, 1, 1);
        check("t3_err3", 32'(bus.error), 32'd1);
        check("t3_lockout", 32'(bus.locked_out), 32'd1);
        enter(0, 1, 2, 3);
        check("t3_ign_open", 32'(bus.unlocked), 32'd0);
        check("t3_ign_cnt", 32'(bus.digit_count), 32'd0);
        check("t3_ign_err", 32'(bus.error), 32'd0);
        idle(21);
        check("t3_lock_k29", 32'(bus.locked_out), 32'd1);
        idle(1);
        check("t3_lock_exit", 32'(bus.locked_out), 32'd0);
        enter(0, 1, 2, 3);
        check("t3_open", 32'(bus.unlocked), 32'd1);
        check("t3_excl", 32'(bus.locked_out), 32'd0);
        press(0);
        enter(2, 2, 2, 2);
        check("t3_failcnt_clr", 32'(bus.locked_out), 32'd0);

        // 4: two buttons rising together forces a mismatch
        @(negedge clk);
        bus.btn = 4'b0011;
        @(negedge clk);
        bus.btn = 4'b0000;
        check("t4_multi_cnt", 32'(bus.digit_count), 32'd1);
        press(1);
        press(2);
        press(3);
        check("t4_err", 32'(bus.error), 32'd1);
        check("t4_locked", 32'(bus.unlocked), 32'd0);

        // 5: button held through reset release, then reset in OPEN
        @(negedge clk);
        reset   = 1'b1;
        bus.btn = 4'b0001;
        idle(2);
        reset = 1'b0;
        idle(2);
        bus.btn = 4'b0000;
        idle(1);
        check("t5_held_cnt", 32'(bus.digit_count), 32'd0);
        enter(0, 1, 2, 3);
        check("t5_open", 32'(bus.unlocked), 32'd1);
        reset = 1'b1;
        idle(1);
        check("t5_rst_open", 32'(bus.unlocked), 32'd0);
        reset = 1'b0;
        idle(1);

`ifdef LOCK_REPROGRAM_EN
        // 6: reprogram to 3,3,3,3
        enter(0, 1, 2, 3);
        check("t6_open", 32'(bus.unlocked), 32'd1);
        bus.prog = 1'b1;
        press(3);
        check("t6_set_open", 32'(bus.unlocked), 32'd1);
        press(3);
        press(3);
        press(3);
        bus.prog = 1'b0;
        check("t6_set_done", 32'(bus.unlocked), 32'd0);
        enter(0, 1, 2, 3);
        check("t6_old_err", 32'(bus.error), 32'd1);
        enter(3, 3, 3, 3);
        check("t6_new_open", 32'(bus.unlocked), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
